isqrt_pipe_flow: RTL and testbench

Parametrised pipelined integer square root with valid/ready flow control and remainder output. Computes `y = floor(sqrt(x))` and `r = x - y*y` for unsigned `x` of configurable width, using the restoring bit-pair algorithm. The iterations are split across a configurable number of register stages. Sits between streaming producer/consumer blocks that can apply backpressure, and replaces the fixed 32-bit, always-ready square-root pipeline in designs that need stalls.

---
 rtl/isqrt_pipe_flow.sv | 67 ++++++
 tb/tb_isqrt_pipe_flow.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/isqrt_pipe_flow.sv
// isqrt_pipe_flow: pipelined restoring integer square root with valid/ready flow control and remainder
module isqrt_pipe_flow #(
  parameter int width = 32,
  parameter int n_pipe_stages = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  output logic                 x_rdy,
  input  logic [width-1:0]     x,
  output logic                 y_vld,
  input  logic                 y_rdy,
  output logic [width/2-1:0]   y,
  output logic [width/2:0]     r
);
  localparam int hw = width / 2;
  localparam int ips = hw / n_pipe_stages;
  localparam logic [width-1:0] m0 = {2'b01, {(width-2){1'b0}}};
  logic [n_pipe_stages-1:0] vld, en, up;
  logic [width-1:0] rem_q [n_pipe_stages];
  logic [width-1:0] rem_d [n_pipe_stages];
  logic [hw-1:0] root_q [n_pipe_stages];
  logic [hw-1:0] root_d [n_pipe_stages];
  logic [width-1:0] xr, rt, mk;
  logic ge;
  assign up = n_pipe_stages'({vld, x_vld});
  assign x_rdy = en[0];
  assign y_vld = vld[n_pipe_stages-1];
  assign y = root_q[n_pipe_stages-1];
  assign r = rem_q[n_pipe_stages-1][hw:0];
  always_comb begin
    en = '0;
    en[n_pipe_stages-1] = !vld[n_pipe_stages-1] || y_rdy;
    for (int i = n_pipe_stages - 2; i >= 0; i--) en[i] = !vld[i] || en[i+1];
  end
  // Stage registers keep the partial root unscaled; rescale it to the running m before iterating.
  always_comb begin
    xr = '0;
    rt = '0;
    mk = '0;
    ge = 1'b0;
    for (int s = 0; s < n_pipe_stages; s++) begin
      xr = s == 0 ? x : rem_q[s == 0 ? 0 : s - 1];
      rt = s == 0 ? '0 : width'(root_q[s == 0 ? 0 : s - 1]) << (width - 2 * s * ips);
      for (int k = 0; k < ips; k++) begin
        mk = m0 >> (2 * (s * ips + k));
        ge = xr >= (rt | mk);
        xr = ge ? xr - (rt | mk) : xr;
        rt = (rt >> 1) | (ge ? mk : '0);
      end
      rem_d[s] = xr;
      root_d[s] = hw'(rt >> (width - 2 * (s + 1) * ips));
    end
  end
  always_ff @(posedge clk) begin
    vld <= !rst ? '0 : (en & up) | (~en & vld);
    for (int i = 0; i < n_pipe_stages; i++)
      if (en[i]) begin
        rem_q[i] <= rem_d[i];
        root_q[i] <= root_d[i];
      end
    if (!rst) begin
      rem_q[n_pipe_stages-1] <= '0;
      root_q[n_pipe_stages-1] <= '0;
    end
  end
endmodule

// File: tb/tb_isqrt_pipe_flow.sv
// tb_isqrt_pipe_flow: directed and scoreboard checks of isqrt_pipe_flow in three configurations
module tb_isqrt_pipe_flow;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic x_vld_a = 0, x_rdy_a, y_vld_a, y_rdy_a = 1;
  logic [31:0] x_a = 0;
  logic [15:0] y_a;
  logic [16:0] r_a;
  logic x_vld_b = 0, x_rdy_b, y_vld_b, y_rdy_b = 1;
  logic [15:0] x_b = 0;
  logic [7:0] y_b;
  logic [8:0] r_b;
  logic x_vld_c = 0, x_rdy_c, y_vld_c, y_rdy_c = 1;
  logic [7:0] x_c = 0;
  logic [3:0] y_c;
  logic [4:0] r_c;
  isqrt_pipe_flow #(.width(32), .n_pipe_stages(4)) dut_a (.clk(clk), .rst(rst), .x_vld(x_vld_a), .x_rdy(x_rdy_a),
    .x(x_a), .y_vld(y_vld_a), .y_rdy(y_rdy_a), .y(y_a), .r(r_a));
  isqrt_pipe_flow #(.width(16), .n_pipe_stages(8)) dut_b (.clk(clk), .rst(rst), .x_vld(x_vld_b), .x_rdy(x_rdy_b),
    .x(x_b), .y_vld(y_vld_b), .y_rdy(y_rdy_b), .y(y_b), .r(r_b));
  isqrt_pipe_flow #(.width(8), .n_pipe_stages(1)) dut_c (.clk(clk), .rst(rst), .x_vld(x_vld_c), .x_rdy(x_rdy_c),
    .x(x_c), .y_vld(y_vld_c), .y_rdy(y_rdy_c), .y(y_c), .r(r_c));

  function automatic longint isqrt(longint v);
    longint q = longint'($sqrt(real'(v)));
    while (q * q > v) q--;
    while ((q + 1) * (q + 1) <= v) q++;
    return q;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for the 32/4 instance: every accepted operand is in flight until it leaves.
  logic [31:0] sb[$];
  logic held = 0;
  logic [15:0] hy;
  logic [16:0] hr;
  longint xe, ye;
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      held = 0;
    end else begin
      chk("x_rdy_a", x_rdy_a, sb.size() < 4 || y_rdy_a);
      if (sb.size() == 0) chk("idle_y_vld_a", y_vld_a, 0);
      if (held) begin
        chk("hold_vld_a", y_vld_a, 1);
        chk("hold_y_a", y_a, hy);
        chk("hold_r_a", r_a, hr);
      end
      held = y_vld_a && !y_rdy_a;
      hy = y_a;
      hr = r_a;
      if (y_vld_a && y_rdy_a && sb.size() > 0) begin
        xe = sb.pop_front();
        ye = isqrt(xe);
        chk("y_a", y_a, ye);
        chk("r_a", r_a, xe - ye * ye);
      end
      if (x_vld_a && x_rdy_a) sb.push_back(x_a);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [31:0] v, input longint ey, input longint er);
    int lat = 0;
    x_a = v;
    x_vld_a = 1;
    do begin
      cyc(1);
      lat++;
      if (lat == 1) x_vld_a = 0;
    end while (!y_vld_a && lat < 50);
    chk("lat_a", lat, 4);
    chk("y_a_lit", y_a, ey);
    chk("r_a_lit", r_a, er);
    cyc(1);
  endtask

  task automatic send_b(input logic [15:0] v, input longint ey, input longint er);
    int lat = 0;
    x_b = v;
    x_vld_b = 1;
    do begin
      cyc(1);
      lat++;
      if (lat == 1) x_vld_b = 0;
    end while (!y_vld_b && lat < 50);
    chk("lat_b", lat, 8);
    chk("y_b_lit", y_b, ey);
    chk("r_b_lit", r_b, er);
    cyc(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst = 1;
    chk("rst_y_vld_a", y_vld_a, 0);
    chk("rst_y_a", y_a, 0);
    chk("rst_r_a", r_a, 0);
    chk("rst_x_rdy_a", x_rdy_a, 1);
    chk("rst_y_vld_b", y_vld_b, 0);
    chk("rst_y_vld_c", y_vld_c, 0);
    send_a(32'd0, 0, 0);
    send_a(32'd1, 1, 0);
    send_a(32'hFFFF_FFFF, 64'hFFFF, 64'h1_FFFE);
    send_a(32'd1_000_000, 1000, 0);
    for (int i = 0; i < 64; i++) begin
      x_a = $urandom;
      x_vld_a = 1;
      cyc(1);
    end
    x_vld_a = 0;
    cyc(8);
    chk("stream_left_a", sb.size(), 0);
    y_rdy_a = 0;
    for (int i = 0; i < 10; i++) begin
      x_a = $urandom;
      x_vld_a = 1;
      cyc(1);
    end
    chk("bp_x_rdy_a", x_rdy_a, 0);
    chk("bp_occ_a", sb.size(), 4);
    y_rdy_a = 1;
    for (int i = 0; i < 3; i++) begin
      x_a = $urandom;
      cyc(1);
    end
    x_vld_a = 0;
    cyc(8);
    chk("bp_left_a", sb.size(), 0);
    for (int i = 0; i < 300; i++) begin
      x_a = $urandom;
      x_vld_a = 1'($urandom_range(0, 1));
      y_rdy_a = 1'($urandom_range(0, 1));
      cyc(1);
    end
    x_vld_a = 0;
    y_rdy_a = 1;
    cyc(8);
    chk("rand_left_a", sb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      x_a = $urandom;
      x_vld_a = 1;
      cyc(1);
    end
    x_vld_a = 0;
    rst = 0;
    cyc(1);
    rst = 1;
    chk("mid_rst_y_vld_a", y_vld_a, 0);
    chk("mid_rst_y_a", y_a, 0);
    chk("mid_rst_r_a", r_a, 0);
    cyc(6);
    send_a(32'd49, 7, 0);
    send_b(16'hFFFF, 64'hFF, 64'h1FE);
    send_b(16'h0100, 16, 0);
    send_b(16'd2, 1, 1);
    send_b(16'd15, 3, 6);
    for (int i = 0; i < 256; i++) begin
      x_c = 8'(i);
      x_vld_c = 1;
      cyc(1);
      chk("y_vld_c", y_vld_c, 1);
      chk("y_c", y_c, isqrt(i));
      chk("r_c", r_c, i - isqrt(i) * isqrt(i));
    end
    x_vld_c = 0;
    cyc(1);
    chk("idle_y_vld_c", y_vld_c, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
